serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial subtraction controller. Computes A - B over WIDTH-bit operands by
//  reusing one 1-bit full subtractor for WIDTH cycles, LSB first.
//  - Sequences operand shifting and borrow propagation.
//  - Presents the result through a start/busy/done handshake.
//  - Sits between a host/sequencer and the full-subtractor datapath; trades
//    latency for area.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk         in   1      system clock; all state changes on rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  A           in   WIDTH  minuend; captured on the accepting edge
//  B           in   WIDTH  subtrahend; captured on the accepting edge
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse; result valid
//  diff        out  WIDTH  A - B modulo 2^WIDTH; held until next completion
//  borrow_out  out  1      final borrow (1 means A < B unsigned); held with diff
// BEHAVIOUR
//  Reset
//  - rst=1 forces state IDLE immediately.
//  - busy, done, borrow_out, diff, internal shift registers, bit counter and
//    borrow flop all go to 0.
//  - Reset mid-RUN aborts the operation; no done is issued.
//  FSM
//  - IDLE -> RUN: at an edge with start=1.
//      * Load a_sh<=A, b_sh<=B; clear borrow and cnt.
//      * Ignore start=0.
//  - RUN: each edge performs one full-subtract step on bits (a_sh[0], b_sh[0], borrow):
//      * d = a^b^bin
//      * bout = (~a&b) | (~(a^b)&bin)
//      * Shift a_sh and b_sh right by 1.
//      * Shift d into the MSB of r_sh.
//      * borrow <= bout; cnt <= cnt+1.
//  - RUN -> DONE: on the edge processing the last bit (cnt==WIDTH-1).
//      * On that same edge, load the diff register with the completed r_sh value,
//        including the final d bit.
//      * Load borrow_out with bout.
//  - DONE -> IDLE: unconditionally on the next edge.
//  Handshake outputs
//  - busy=1 exactly in RUN.
//  - done=1 exactly in DONE (one cycle).
//  Timing
//  - Latency: start accepted at edge k -> RUN for edges k+1..k+WIDTH -> done
//    high in the cycle after edge k+WIDTH.
//  - Throughput: a new start is accepted no sooner than the edge after DONE, so
//    the minimum issue interval is WIDTH+2 cycles.
//  Boundary conditions
//  - start asserted in RUN or DONE is ignored; it is not queued. The host must
//    hold or re-assert start in IDLE.
//  - A/B changes after the accepting edge have no effect on the operation in
//    progress.
//  - Result registers never update during RUN. The previous diff/borrow_out stay
//    visible until the next DONE.
//  - Arithmetic is unsigned modulo 2^WIDTH. Signed callers interpret diff as
//    two's complement; borrow_out is then not an overflow flag.
//  - cnt is $clog2(WIDTH) bits wide. It never wraps past WIDTH-1 in RUN.
// TESTING
//  1. WIDTH=8, A=0x5A, B=0x23, start 1 cycle -> busy 8 cycles, done pulse, diff=0x37, borrow_out=0
//  2. A=0x10, B=0x20 -> diff=0xF0, borrow_out=1; A=0x00, B=0x01 -> diff=0xFF, borrow_out=1
//  3. A=0xFF, B=0xFF -> diff=0x00, borrow_out=0; then A=0xFF, B=0x00 -> diff=0xFF, borrow_out=0
//  4. start=1 held through RUN with A/B changed mid-op -> exactly one result for captured
//     operands; next op begins only after IDLE
//  5. rst pulse at 4th RUN cycle -> outputs 0 immediately, no done; subsequent op 0x80-0x01 gives 0x7F
//  6. Back-to-back ops with start held high -> done pulses spaced WIDTH+2 cycles; results
//     hold stable between pulses

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B: one full-subtract step per clock, LSB first, with a
// start/busy/done handshake. Results stay visible until the next completion.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bo_q, bo_d;
  logic             d_bit, bout;

  assign d_bit = a_q[0] ^ b_q[0] ^ brw_q;
  assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bo_q    <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          r_d     = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {d_bit, r_q[WIDTH-1:1]};
        brw_d = bout;
        cnt_d = cnt_q + CW'(1);
        // Final bit: publish the fully shifted result on this same edge.
        if (cnt_q == LAST) begin
          diff_d  = {d_bit, r_q[WIDTH-1:1]};
          bo_d    = bout;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops them on done and checks hold/latency/spacing.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W:0] exp_q[$];

  logic       chk_spacing = 1'b0;
  logic       spc_seen    = 1'b0;
  int         last_done   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: result check on done, hold check otherwise, busy run length, spacing.
  initial begin : monitor
    logic [W:0] held;
    logic [W:0] e;
    int         busy_run;
    held = '0;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_outs", {busy, done, borrow_out, diff}, '0);
        held = '0;
        busy_run = 0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {borrow_out, diff}, e);
          held = e;
        end
        chk("busy_len", busy_run, W);
        busy_run = 0;
        if (chk_spacing) begin
          if (spc_seen) chk("done_spacing", cyc - last_done, W + 2);
          spc_seen = 1'b1;
          last_done = cyc;
        end
      end else begin
        chk("hold", {borrow_out, diff}, held);
        if (busy) busy_run++;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      $display("FAIL wait_idle: busy=%0b done=%0b expected both 0", busy, done);
      n_err++;
      n_cmp++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb);
    wait_idle();
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back({eb, ed});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin : stim
    int n;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bo", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h5A, 8'h23, 8'h37, 1'b0);
    do_op(8'h10, 8'h20, 8'hF0, 1'b1);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1);
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0);
    do_op(8'hFF, 8'h00, 8'hFF, 1'b0);

    // start held through RUN/DONE with operands changed: only one result.
    wait_idle();
    A = 8'h33; B = 8'h11; start = 1'b1;
    exp_q.push_back({1'b0, 8'h22});
    @(posedge clk);
    #1 A = 8'h00; B = 8'hFF;
    repeat (W + 1) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_restart_busy", busy, 0);

    // Reset during the 4th RUN cycle aborts without done.
    wait_idle();
    A = 8'h12; B = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bo", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h80, 8'h01, 8'h7F, 1'b0);

    // Back-to-back with start held high.
    wait_idle();
    spc_seen = 1'b0;
    chk_spacing = 1'b1;
    A = 8'h5A; B = 8'h23; start = 1'b1;
    exp_q.push_back({1'b0, 8'h37});
    @(posedge clk);
    for (int i = 1; i < 3; i++) begin
      #1;
      if (i == 1) begin A = 8'h80; B = 8'h01; exp_q.push_back({1'b0, 8'h7F}); end
      else        begin A = 8'h00; B = 8'hFF; exp_q.push_back({1'b1, 8'h01}); end
      repeat (W + 2) @(posedge clk);
    end
    #1 start = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    wait_idle();
    chk_spacing = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
